// File: rtl/spi1_target_if.sv
// rtl/spi1_target_if.sv - byte-stream side of the SPI1 target front end
interface spi1_target_if;
  logic       start_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       busy_i;
  logic       overrun_o;
  logic       spi_stall_o;

  modport master (
    output start_o, rx_data_o, rx_valid_o, overrun_o, spi_stall_o,
    input  rx_ready_i, tx_data_i, busy_i
  );

  modport slave (
    input  start_o, rx_data_o, rx_valid_o, overrun_o, spi_stall_o,
    output rx_ready_i, tx_data_i, busy_i
  );
endinterface

// File: rtl/spi1_target.sv
// rtl/spi1_target.sv - SPI1 mode-0 target turning the MCU link into a byte stream
module spi1_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             spi1_cs_ni,
  input  logic             spi1_sck_i,
  input  logic             spi1_sd_i,
  output logic             spi1_sd_o,
  spi1_target_if.master    bus
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic [SYNC_STAGES-1:0] r_flush;
  logic                   r_cs_d;
  logic                   r_sck_d;
  logic                   r_armed;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic       r_sd_o;
  logic       r_start;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;

  logic w_cs_s;
  logic w_sck_s;
  logic w_sd_s;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_accept;

  assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
  assign w_sd_s  = r_sd_sync[SYNC_STAGES-1];

  // A falling CS only counts once CS has really been seen high after reset,
  // so a reset released while CS is held low cannot start a bogus frame.
  assign w_cs_fall  = r_armed & r_cs_d & ~w_cs_s;
  assign w_cs_rise  = ~r_cs_d & w_cs_s;
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_accept   = r_rx_valid & bus.rx_ready_i;

  // Synchronize the SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cs_sync  <= '1;
      r_sck_sync <= '0;
      r_sd_sync  <= '0;
      r_flush    <= '0;
      r_cs_d     <= 1'b1;
      r_sck_d    <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi1_cs_ni};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi1_sck_i};
      r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], spi1_sd_i};
      r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_cs_d     <= w_cs_s;
      r_sck_d    <= w_sck_s;
      r_armed    <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs_s);
    end
  end

  // Frame FSM: shifts MOSI in on SCK rise, MISO out on SCK fall, hands bytes off.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 7'd0;
      r_tx_shift <= 8'd0;
      r_sd_o     <= 1'b0;
      r_start    <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_start    <= 1'b1;
            r_overrun  <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
            r_sd_o     <= bus.tx_data_i[7];
            r_tx_shift <= {bus.tx_data_i[6:0], 1'b0};
          end
        end
        ST_ACTIVE: begin
          // CS release takes priority over any SCK edge seen in the same cycle.
          if (w_cs_rise) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_sd_o    <= 1'b0;
          end else if (w_sck_rise) begin
            r_rx_shift <= {r_rx_shift[5:0], w_sd_s};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_data  <= {r_rx_shift, w_sd_s};
              r_rx_valid <= 1'b1;
              if (r_rx_valid && !bus.rx_ready_i) begin
                r_overrun <= 1'b1;
              end
            end
          end else if (w_sck_fall) begin
            if (r_bit_cnt != 3'd0) begin
              r_sd_o     <= r_tx_shift[7];
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end else begin
              r_sd_o     <= bus.tx_data_i[7];
              r_tx_shift <= {bus.tx_data_i[6:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spi1_sd_o       = r_sd_o;
  assign bus.start_o     = r_start;
  assign bus.rx_data_o   = r_rx_data;
  assign bus.rx_valid_o  = r_rx_valid;
  assign bus.overrun_o   = r_overrun;
  assign bus.spi_stall_o = r_rx_valid | bus.busy_i;

endmodule

// File: tb/tb_spi1_target.sv
// tb/tb_spi1_target.sv - directed self-checking bench for spi1_target
`timescale 1ns/1ps
module tb_spi1_target;

  logic clk = 1'b0;
  always #8 clk = ~clk;

  logic rst_n;
  logic cs_n;
  logic sck;
  logic mosi;
  logic miso_pin;

  spi1_target_if u_if ();

  spi1_target #(.SYNC_STAGES(2)) dut (
    .clock_i    (clk),
    .reset_ni   (rst_n),
    .spi1_cs_ni (cs_n),
    .spi1_sck_i (sck),
    .spi1_sd_i  (mosi),
    .spi1_sd_o  (miso_pin),
    .bus        (u_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int valid_cycles = 0;
  logic [7:0] cap[$];

  // Observe the byte stream away from the active edge.
  always @(negedge clk) begin
    if (u_if.start_o) start_cnt++;
    if (u_if.rx_valid_o) valid_cycles++;
    if (u_if.rx_valid_o && u_if.rx_ready_i) cap.push_back(u_if.rx_data_o);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    start_cnt = 0;
    valid_cycles = 0;
    cap.delete();
  endtask

  task automatic spi_bit(input logic b, output logic so);
    mosi = b;
    tick(5);
    so = miso_pin;
    sck = 1'b1;
    tick(5);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] d, output logic [7:0] so);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], b);
      so[i] = b;
    end
  endtask

  task automatic cs_end();
    tick(5);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_vec++; if (miso_pin !== 1'b0) begin n_err++; $display("FAIL reset_sd_o got=%b exp=0", miso_pin); end
    n_vec++; if (u_if.spi_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", u_if.spi_stall_o); end
    n_vec++; if (u_if.start_o !== 1'b0) begin n_err++; $display("FAIL reset_start got=%b exp=0", u_if.start_o); end
    n_vec++; if (u_if.rx_data_o !== 8'h00) begin n_err++; $display("FAIL reset_rx_data got=%h exp=00", u_if.rx_data_o); end
    n_vec++; if (u_if.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got=%b exp=0", u_if.rx_valid_o); end
    n_vec++; if (u_if.overrun_o !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b exp=0", u_if.overrun_o); end
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_single_byte();
    logic [7:0] so;
    logic b;
    clear_mon();
    u_if.tx_data_i = 8'h3C;
    u_if.rx_ready_i = 1'b0;
    cs_n = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      spi_bit(logic'(8'hA5 >> i), b);
      so[i] = b;
    end
    mosi = 1'b1;
    tick(5);
    so[0] = miso_pin;
    sck = 1'b1;
    tick(2);
    n_vec++; if (u_if.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_early got=%b exp=0", u_if.rx_valid_o); end
    tick(1);
    n_vec++; if (u_if.rx_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid_latency got=%b exp=1", u_if.rx_valid_o); end
    n_vec++; if (u_if.spi_stall_o !== 1'b1) begin n_err++; $display("FAIL single_stall_rise got=%b exp=1", u_if.spi_stall_o); end
    tick(2);
    sck = 1'b0;
    tick(5);
    n_vec++; if (start_cnt !== 1) begin n_err++; $display("FAIL single_start_pulses got=%0d exp=1", start_cnt); end
    n_vec++; if (so !== 8'h3C) begin n_err++; $display("FAIL single_miso got=%h exp=3c", so); end
    n_vec++; if (u_if.rx_data_o !== 8'hA5) begin n_err++; $display("FAIL single_rx_data got=%h exp=a5", u_if.rx_data_o); end
    n_vec++; if (u_if.spi_stall_o !== 1'b1) begin n_err++; $display("FAIL single_stall_held got=%b exp=1", u_if.spi_stall_o); end
    u_if.rx_ready_i = 1'b1;
    tick(1);
    u_if.rx_ready_i = 1'b0;
    n_vec++; if (u_if.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_clear got=%b exp=0", u_if.rx_valid_o); end
    n_vec++; if (u_if.spi_stall_o !== 1'b0) begin n_err++; $display("FAIL single_stall_clear got=%b exp=0", u_if.spi_stall_o); end
    cs_end();
  endtask

  task automatic test_back_to_back();
    logic [7:0] so1, so2;
    clear_mon();
    u_if.rx_ready_i = 1'b1;
    u_if.tx_data_i = 8'h3C;
    cs_n = 1'b0;
    tick(5);
    u_if.tx_data_i = 8'hC3;
    spi_byte(8'h12, so1);
    spi_byte(8'h34, so2);
    cs_end();
    n_vec++; if (so1 !== 8'h3C) begin n_err++; $display("FAIL b2b_miso0 got=%h exp=3c", so1); end
    n_vec++; if (so2 !== 8'hC3) begin n_err++; $display("FAIL b2b_miso1 got=%h exp=c3", so2); end
    n_vec++; if (valid_cycles !== 2) begin n_err++; $display("FAIL b2b_valid_cycles got=%0d exp=2", valid_cycles); end
    n_vec++; if (cap.size() !== 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", cap.size()); end
    else begin
      n_vec++; if (cap[0] !== 8'h12) begin n_err++; $display("FAIL b2b_byte0 got=%h exp=12", cap[0]); end
      n_vec++; if (cap[1] !== 8'h34) begin n_err++; $display("FAIL b2b_byte1 got=%h exp=34", cap[1]); end
    end
    n_vec++; if (u_if.overrun_o !== 1'b0) begin n_err++; $display("FAIL b2b_overrun got=%b exp=0", u_if.overrun_o); end
    u_if.rx_ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] so;
    clear_mon();
    u_if.rx_ready_i = 1'b0;
    cs_n = 1'b0;
    spi_byte(8'h01, so);
    spi_byte(8'h02, so);
    cs_end();
    n_vec++; if (u_if.rx_data_o !== 8'h02) begin n_err++; $display("FAIL ovr_rx_data got=%h exp=02", u_if.rx_data_o); end
    n_vec++; if (u_if.overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", u_if.overrun_o); end
    n_vec++; if (u_if.rx_valid_o !== 1'b1) begin n_err++; $display("FAIL ovr_valid got=%b exp=1", u_if.rx_valid_o); end
    u_if.rx_ready_i = 1'b1;
    tick(1);
    u_if.rx_ready_i = 1'b0;
    n_vec++; if (u_if.overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", u_if.overrun_o); end
    clear_mon();
    cs_n = 1'b0;
    tick(4);
    n_vec++; if (start_cnt !== 1) begin n_err++; $display("FAIL ovr_restart got=%0d exp=1", start_cnt); end
    n_vec++; if (u_if.overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", u_if.overrun_o); end
    cs_end();
  endtask

  task automatic test_abort();
    logic b;
    logic [7:0] so;
    clear_mon();
    u_if.rx_ready_i = 1'b1;
    cs_n = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(1'b0, b);
    cs_end();
    n_vec++; if (valid_cycles !== 0) begin n_err++; $display("FAIL abort_valid_cycles got=%0d exp=0", valid_cycles); end
    n_vec++; if (u_if.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_valid got=%b exp=0", u_if.rx_valid_o); end
    u_if.rx_ready_i = 1'b0;
    cs_n = 1'b0;
    spi_byte(8'hFF, so);
    cs_end();
    n_vec++; if (u_if.rx_data_o !== 8'hFF) begin n_err++; $display("FAIL abort_next_data got=%h exp=ff", u_if.rx_data_o); end
    n_vec++; if (u_if.rx_valid_o !== 1'b1) begin n_err++; $display("FAIL abort_next_valid got=%b exp=1", u_if.rx_valid_o); end
    u_if.rx_ready_i = 1'b1;
    tick(1);
    u_if.rx_ready_i = 1'b0;
  endtask

  task automatic test_busy();
    u_if.busy_i = 1'b1;
    #1;
    n_vec++; if (u_if.spi_stall_o !== 1'b1) begin n_err++; $display("FAIL busy_stall got=%b exp=1", u_if.spi_stall_o); end
    u_if.busy_i = 1'b0;
    #1;
    n_vec++; if (u_if.spi_stall_o !== 1'b0) begin n_err++; $display("FAIL busy_release got=%b exp=0", u_if.spi_stall_o); end
    tick(1);
  endtask

  task automatic test_reset_midframe();
    logic b;
    logic [7:0] so;
    u_if.tx_data_i = 8'h3C;
    u_if.rx_ready_i = 1'b0;
    cs_n = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    tick(5);
    n_vec++; if (miso_pin !== 1'b1) begin n_err++; $display("FAIL mid_sd_before got=%b exp=1", miso_pin); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (miso_pin !== 1'b0) begin n_err++; $display("FAIL mid_sd_o got=%b exp=0", miso_pin); end
    n_vec++; if (u_if.rx_data_o !== 8'h00) begin n_err++; $display("FAIL mid_rx_data got=%h exp=00", u_if.rx_data_o); end
    n_vec++; if (u_if.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rx_valid got=%b exp=0", u_if.rx_valid_o); end
    n_vec++; if (u_if.start_o !== 1'b0) begin n_err++; $display("FAIL mid_start got=%b exp=0", u_if.start_o); end
    n_vec++; if (u_if.overrun_o !== 1'b0) begin n_err++; $display("FAIL mid_overrun got=%b exp=0", u_if.overrun_o); end
    n_vec++; if (u_if.spi_stall_o !== 1'b0) begin n_err++; $display("FAIL mid_stall got=%b exp=0", u_if.spi_stall_o); end
    tick(2);
    rst_n = 1'b1;
    tick(6);
    clear_mon();
    spi_byte(8'h55, so);
    tick(4);
    n_vec++; if (valid_cycles !== 0) begin n_err++; $display("FAIL mid_no_valid got=%0d exp=0", valid_cycles); end
    n_vec++; if (start_cnt !== 0) begin n_err++; $display("FAIL mid_no_start got=%0d exp=0", start_cnt); end
    cs_n = 1'b1;
    tick(6);
    clear_mon();
    cs_n = 1'b0;
    spi_byte(8'h5A, so);
    cs_end();
    n_vec++; if (start_cnt !== 1) begin n_err++; $display("FAIL mid_fresh_start got=%0d exp=1", start_cnt); end
    n_vec++; if (u_if.rx_data_o !== 8'h5A) begin n_err++; $display("FAIL mid_fresh_data got=%h exp=5a", u_if.rx_data_o); end
    n_vec++; if (u_if.rx_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_fresh_valid got=%b exp=1", u_if.rx_valid_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    u_if.rx_ready_i = 1'b0;
    u_if.tx_data_i = 8'h00;
    u_if.busy_i = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_busy();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi1_target.md
# spi1_target

SPI1 target front end: receives the MCU's SPI1 link (mode 0, MSB first) and turns it into a byte stream in the 64 MHz `clock_i` domain. It sits directly downstream of the top-level SPI1 pins and feeds the bus-command decoder inside `main`, which issues RAM/IO transactions. The block also returns one response byte per received byte and drives `spi_stall_o` so the MCU holds off while a byte or transaction is still pending.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `spi1_cs_ni`, `spi1_sck_i`, `spi1_sd_i` (must be ≥2).

Ports:
- `clock_i` in 1: 64 MHz system clock.
- `reset_ni` in 1: reset, asynchronous and active-low.
- `spi1_cs_ni` in 1: SPI chip select, active low, asynchronous to `clock_i`.
- `spi1_sck_i` in 1: SPI clock, idle low, ≤ `clock_i`/8.
- `spi1_sd_i` in 1: MCU→FPGA serial data.
- `spi1_sd_o` out 1: FPGA→MCU serial data.
- `spi_stall_o` out 1: high = MCU must not start the next byte.
- `start_o` out 1: one-cycle pulse on synchronized CS falling edge (frame start).
- `rx_data_o` out 8: last complete received byte.
- `rx_valid_o` out 1: `rx_data_o` holds an unconsumed byte.
- `rx_ready_i` in 1: consumer accepts byte when high with `rx_valid_o`.
- `tx_data_i` in 8: response byte, sampled at frame start and at each byte boundary.
- `busy_i` in 1: downstream transaction in progress; forces stall.
- `overrun_o` out 1: sticky, byte completed while `rx_valid_o` still high.

## Operation
- Sync: each SPI input passes through `SYNC_STAGES` flops. The edge detector compares the synced value with one extra delayed copy. Resets: synced CS=1, SCK=0, SD=0.
- States: IDLE (synced CS high), ACTIVE (synced CS low).
- IDLE→ACTIVE on synced CS falling edge:
  - pulse `start_o`;
  - `bit_cnt`←0, `rx_shift`←0;
  - `spi1_sd_o`←`tx_data_i[7]`, `tx_shift`←`{tx_data_i[6:0],1'b0}`.
- ACTIVE, synced SCK rising edge:
  - `rx_shift`←`{rx_shift[6:0], sd_sync}`;
  - `bit_cnt`←`bit_cnt+1` (3-bit, wraps 7→0).
  - When `bit_cnt` was 7 (byte complete): `rx_data_o`←`{rx_shift[6:0], sd_sync}`, `rx_valid_o`←1. If `rx_valid_o` was already 1 and not consumed that cycle, also set `overrun_o`←1. The old byte is overwritten.
- ACTIVE, synced SCK falling edge:
  - `bit_cnt`≠0: `spi1_sd_o`←`tx_shift[7]`, `tx_shift`←`tx_shift<<1`.
  - `bit_cnt`=0 (byte boundary): reload, `spi1_sd_o`←`tx_data_i[7]`, `tx_shift`←`{tx_data_i[6:0],0}`.
- `spi1_sd_o` changes only on CS fall or SCK fall, never on SCK rise.
- Handshake: `rx_valid_o` clears on a cycle with `rx_valid_o & rx_ready_i`. If byte completion and acceptance occur in the same cycle, the new byte wins: valid stays 1 and there is no overrun.
- ACTIVE→IDLE on synced CS rising edge:
  - partial byte discarded, `bit_cnt`←0, no `rx_valid_o`;
  - a pending complete byte stays valid;
  - `spi1_sd_o`←0.
- Simultaneous CS rise and SCK edge in the same cycle: the CS edge wins and the SCK edge is ignored.
- `spi_stall_o` = `rx_valid_o | busy_i` (combinational from registers and input).
- `overrun_o` clears only on `start_o` or reset.

## Timing
- Reset values:
  - `spi1_sd_o`=0, `spi_stall_o`=0 (`busy_i` low), `start_o`=0;
  - `rx_data_o`=8'h00, `rx_valid_o`=0, `overrun_o`=0;
  - `bit_cnt`=0, state IDLE.
- Reset mid-frame aborts everything. After release, the block waits in IDLE until a fresh CS falling edge, even if CS is still low.
- Latency from pin edge to internal action is `SYNC_STAGES`+1 clocks: 3 clocks at default (≈47 ns).
- `rx_valid_o` rises `SYNC_STAGES`+1 clocks after the 8th SCK rising pin edge. `spi_stall_o` rises in the same cycle.
- `spi1_sd_o` updates `SYNC_STAGES`+1 clocks after SCK falling or CS falling pin edge. The MCU must allow ≥4 clocks from CS fall to first SCK rise.
- SCK high and low phases must each be ≥4 clocks.

## Test plan
- Reset then CS low, shift 8'hA5 with `tx_data_i`=8'h3C → `start_o` one pulse; MCU samples 8'h3C; `rx_data_o`=8'hA5, `rx_valid_o`=1, `spi_stall_o`=1 until `rx_ready_i`.
- Two-byte frame 8'h12, 8'h34, `rx_ready_i` tied high, `tx_data_i` changed 8'h3C→8'hC3 before the 8th falling edge → two single-cycle valids (12, 34); second MISO byte 8'hC3; `overrun_o`=0.
- Two bytes 8'h01, 8'h02 with `rx_ready_i`=0 → `rx_data_o`=8'h02, `overrun_o`=1. The next CS fall clears `overrun_o`.
- CS rises after 5 SCK bits → no `rx_valid_o`, `bit_cnt`=0. The next frame sends 8'hFF → `rx_data_o`=8'hFF.
- `busy_i`=1 with no pending byte → `spi_stall_o`=1. Drop `busy_i` → `spi_stall_o`=0 next evaluation.
- Assert `reset_ni`=0 after bit 4 while CS stays low → all outputs at reset values. SCK pulses after reset produce no `rx_valid_o` until CS toggles high then low.
